// File: rtl/acc_pkg.sv
// Shared types for the accumulator bank: command op-codes and FSM states.
package acc_pkg;

  typedef enum logic [2:0] {
    OP_NOP      = 3'd0,
    OP_LOAD_BUS = 3'd1,
    OP_LOAD_ALU = 3'd2,
    OP_INC      = 3'd3,
    OP_DEC      = 3'd4,
    OP_CLR      = 3'd5,
    OP_SHL      = 3'd6,
    OP_SHR      = 3'd7
  } acc_op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } acc_state_e;

endpackage

// File: rtl/acc_alu_step.sv
// One-step arithmetic for an accumulator: INC/DEC (wrapping or saturating)
// and single-bit zero-filling shifts, with the matching carry/borrow/shift-out bit.
module acc_alu_step
  import acc_pkg::*;
#(
  parameter int W   = 12,
  parameter bit SAT = 1'b0
) (
  input  acc_op_e        op,
  input  logic [W-1:0]   value,
  output logic [W-1:0]   next_val,
  output logic           carry_out
);

  logic all_ones;
  logic all_zero;

  assign all_ones = &value;
  assign all_zero = ~|value;

  // Next value and carry for a single step of the requested operation
  always_comb begin
    next_val  = value;
    carry_out = 1'b0;
    case (op)
      OP_INC: begin
        carry_out = all_ones;
        next_val  = (SAT && all_ones) ? value : value + W'(1);
      end
      OP_DEC: begin
        carry_out = all_zero;
        next_val  = (SAT && all_zero) ? value : value - W'(1);
      end
      OP_SHL: begin
        carry_out = value[W-1];
        next_val  = {value[W-2:0], 1'b0};
      end
      OP_SHR: begin
        carry_out = value[0];
        next_val  = {1'b0, value[W-1:1]};
      end
      default: begin
        next_val  = value;
        carry_out = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/acc_bank.sv
// Accumulator bank between the data bus and the ALU: single-cycle load/inc/dec/clr,
// multi-cycle serial shifts behind a ready/valid handshake, and an R capture register.
module acc_bank
  import acc_pkg::*;
#(
  parameter int W       = 12,
  parameter int NUM_ACC = 4,
  parameter bit SAT     = 1'b0,
  localparam int SELW   = $clog2(NUM_ACC),
  localparam int SHW    = $clog2(W)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [2:0]      cmd_op,
  input  logic [SELW-1:0] cmd_sel,
  input  logic [SHW-1:0]  cmd_shamt,
  input  logic [W-1:0]    bus_in,
  input  logic [W-1:0]    alu_res,
  input  logic            r_load,
  input  logic [SELW-1:0] out_sel,
  output logic [W-1:0]    acc_out,
  output logic [W-1:0]    alu_opnd,
  output logic [W-1:0]    r_out,
  output logic            zero,
  output logic            carry,
  output logic            busy
);

  acc_state_e      state;
  acc_state_e      state_next;
  logic [W-1:0]    acc [NUM_ACC];
  logic [SELW-1:0] shift_sel;
  logic            shift_dir;
  logic [SHW-1:0]  count;

  acc_op_e         op_in;
  logic            accept;
  acc_op_e         step_op;
  logic [SELW-1:0] step_sel;
  logic [W-1:0]    step_val;
  logic            step_carry;

  logic            wr_en;
  logic [SELW-1:0] wr_sel;
  logic [W-1:0]    wr_val;
  logic            carry_en;
  logic            carry_val;
  logic            opnd_en;
  logic            shift_start;

  assign op_in     = acc_op_e'(cmd_op);
  assign busy      = (state == ST_SHIFT);
  assign cmd_ready = !busy;
  assign accept    = cmd_valid && cmd_ready;
  assign acc_out   = acc[out_sel];

  // The shared step unit works on the shifting accumulator while busy, else on the command target
  assign step_sel = busy ? shift_sel : cmd_sel;
  assign step_op  = busy ? (shift_dir ? OP_SHR : OP_SHL) : op_in;

  acc_alu_step #(
    .W   (W),
    .SAT (SAT)
  ) u_step (
    .op        (step_op),
    .value     (acc[step_sel]),
    .next_val  (step_val),
    .carry_out (step_carry)
  );

  // Next-state and write-control decode
  always_comb begin
    state_next  = state;
    wr_en       = 1'b0;
    wr_sel      = cmd_sel;
    wr_val      = step_val;
    carry_en    = 1'b0;
    carry_val   = step_carry;
    opnd_en     = 1'b0;
    shift_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (op_in)
            OP_LOAD_BUS: begin
              wr_en   = 1'b1;
              wr_val  = bus_in;
              opnd_en = 1'b1;
            end
            OP_LOAD_ALU: begin
              wr_en   = 1'b1;
              wr_val  = alu_res;
              opnd_en = 1'b1;
            end
            OP_INC, OP_DEC: begin
              wr_en    = 1'b1;
              carry_en = 1'b1;
            end
            OP_CLR: begin
              wr_en     = 1'b1;
              wr_val    = '0;
              carry_en  = 1'b1;
              carry_val = 1'b0;
            end
            OP_SHL, OP_SHR: begin
              if (cmd_shamt != '0) begin
                shift_start = 1'b1;
                state_next  = ST_SHIFT;
              end
            end
            default: begin
              wr_en = 1'b0;
            end
          endcase
        end
      end
      ST_SHIFT: begin
        wr_en    = 1'b1;
        wr_sel   = shift_sel;
        carry_en = 1'b1;
        if (count == SHW'(1)) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Accumulator array, written by at most one op per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ACC; i++) begin
        acc[i] <= '0;
      end
    end else if (wr_en) begin
      acc[wr_sel] <= wr_val;
    end
  end

  // Flags and ALU operand register follow whatever was just written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero     <= 1'b0;
      carry    <= 1'b0;
      alu_opnd <= '0;
    end else begin
      if (wr_en) begin
        zero <= (wr_val == '0);
      end
      if (carry_en) begin
        carry <= carry_val;
      end
      if (opnd_en) begin
        alu_opnd <= wr_val;
      end
    end
  end

  // Shift bookkeeping: target, direction and remaining step count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_sel <= '0;
      shift_dir <= 1'b0;
      count     <= '0;
    end else if (shift_start) begin
      shift_sel <= cmd_sel;
      shift_dir <= (op_in == OP_SHR);
      count     <= cmd_shamt;
    end else if (busy) begin
      count <= count - SHW'(1);
    end
  end

  // R register captures the bus independently of the command path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
    end else if (r_load) begin
      r_out <= bus_in;
    end
  end

endmodule

// File: tb/tb_acc_bank.sv
// Self-checking bench for acc_bank: a wrapping and a saturating instance share stimulus
// and are compared against an arithmetic reference model plus hand-computed vectors.
module tb_acc_bank;
  import acc_pkg::*;

  localparam int W    = 12;
  localparam int NA   = 4;
  localparam int MASK = 4095;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic [1:0]  cmd_sel;
  logic [3:0]  cmd_shamt;
  logic [11:0] bus_in;
  logic [11:0] alu_res;
  logic        r_load;
  logic [1:0]  out_sel;

  logic        cmd_ready [2];
  logic [11:0] acc_out   [2];
  logic [11:0] alu_opnd  [2];
  logic [11:0] r_out     [2];
  logic        zero      [2];
  logic        carry     [2];
  logic        busy      [2];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, one copy per instance (index = SAT value)
  int m_acc   [2][NA];
  int m_opnd  [2];
  int m_r     [2];
  int m_zero  [2];
  int m_carry [2];
  int m_shift [2];
  int m_sel   [2];
  int m_dir   [2];
  int m_orig  [2];
  int m_k     [2];
  int m_done  [2];

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  sel;
    logic [11:0] bus;
    logic [11:0] alu;
    logic        rl;
    logic [1:0]  osel;
    logic [11:0] e_acc0;
    logic [11:0] e_acc1;
    logic        e_c0;
    logic        e_c1;
    logic        e_z0;
    logic        e_z1;
    logic [11:0] e_opnd;
    logic [11:0] e_r;
  } vec_t;

  vec_t vecs[$];

  acc_bank #(.W(W), .NUM_ACC(NA), .SAT(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[0]),
    .cmd_op(cmd_op), .cmd_sel(cmd_sel), .cmd_shamt(cmd_shamt), .bus_in(bus_in),
    .alu_res(alu_res), .r_load(r_load), .out_sel(out_sel), .acc_out(acc_out[0]),
    .alu_opnd(alu_opnd[0]), .r_out(r_out[0]), .zero(zero[0]), .carry(carry[0]),
    .busy(busy[0])
  );

  acc_bank #(.W(W), .NUM_ACC(NA), .SAT(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[1]),
    .cmd_op(cmd_op), .cmd_sel(cmd_sel), .cmd_shamt(cmd_shamt), .bus_in(bus_in),
    .alu_res(alu_res), .r_load(r_load), .out_sel(out_sel), .acc_out(acc_out[1]),
    .alu_opnd(alu_opnd[1]), .r_out(r_out[1]), .zero(zero[1]), .carry(carry[1]),
    .busy(busy[1])
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Value of the shifting accumulator after j single-bit steps
  function automatic int shiftedVal(int orig, int dir, int j);
    if (j >= W) return 0;
    return dir != 0 ? (orig >> j) : ((orig << j) & MASK);
  endfunction

  // Bit that left the register on step j (1-based)
  function automatic int shiftedOut(int orig, int dir, int j);
    if (j < 1 || j > W) return 0;
    return dir != 0 ? ((orig >> (j - 1)) & 1) : ((orig >> (W - j)) & 1);
  endfunction

  task automatic modelReset();
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < NA; a++) m_acc[s][a] = 0;
      m_opnd[s] = 0; m_r[s] = 0; m_zero[s] = 0; m_carry[s] = 0;
      m_shift[s] = 0; m_sel[s] = 0; m_dir[s] = 0; m_orig[s] = 0; m_k[s] = 0; m_done[s] = 0;
    end
  endtask

  // Advance the model by one clock edge using the currently driven inputs
  task automatic modelStep(input int s);
    int v;
    if (r_load) m_r[s] = int'(bus_in);
    if (m_shift[s] != 0) begin
      m_done[s]++;
      v = shiftedVal(m_orig[s], m_dir[s], m_done[s]);
      m_acc[s][m_sel[s]] = v;
      m_carry[s] = shiftedOut(m_orig[s], m_dir[s], m_done[s]);
      if (m_done[s] == m_k[s]) begin
        m_shift[s] = 0;
        m_zero[s]  = (v == 0);
      end
    end else if (cmd_valid) begin
      v = m_acc[s][cmd_sel];
      case (cmd_op)
        3'd1: begin
          m_acc[s][cmd_sel] = int'(bus_in); m_opnd[s] = int'(bus_in); m_zero[s] = (bus_in == 0);
        end
        3'd2: begin
          m_acc[s][cmd_sel] = int'(alu_res); m_opnd[s] = int'(alu_res); m_zero[s] = (alu_res == 0);
        end
        3'd3: begin
          if (v == MASK) begin
            m_carry[s] = 1;
            if (s == 0) v = 0;
          end else begin
            m_carry[s] = 0;
            v = v + 1;
          end
          m_acc[s][cmd_sel] = v; m_zero[s] = (v == 0);
        end
        3'd4: begin
          if (v == 0) begin
            m_carry[s] = 1;
            if (s == 0) v = MASK;
          end else begin
            m_carry[s] = 0;
            v = v - 1;
          end
          m_acc[s][cmd_sel] = v; m_zero[s] = (v == 0);
        end
        3'd5: begin
          m_acc[s][cmd_sel] = 0; m_carry[s] = 0; m_zero[s] = 1;
        end
        3'd6, 3'd7: begin
          if (cmd_shamt != 0) begin
            m_shift[s] = 1; m_sel[s] = int'(cmd_sel); m_dir[s] = (cmd_op == 3'd7);
            m_orig[s] = v; m_k[s] = int'(cmd_shamt); m_done[s] = 0;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output of both instances against the model
  task automatic checkModel();
    for (int s = 0; s < 2; s++) begin
      checkOutput($sformatf("acc_out_sat%0d", s), 32'(acc_out[s]), m_acc[s][out_sel]);
      checkOutput($sformatf("alu_opnd_sat%0d", s), 32'(alu_opnd[s]), m_opnd[s]);
      checkOutput($sformatf("r_out_sat%0d", s), 32'(r_out[s]), m_r[s]);
      checkOutput($sformatf("carry_sat%0d", s), 32'(carry[s]), m_carry[s]);
      checkOutput($sformatf("busy_sat%0d", s), 32'(busy[s]), m_shift[s]);
      checkOutput($sformatf("ready_sat%0d", s), 32'(cmd_ready[s]), (m_shift[s] == 0));
      if (m_shift[s] == 0) begin
        checkOutput($sformatf("zero_sat%0d", s), 32'(zero[s]), m_zero[s]);
      end
    end
  endtask

  // Drive one cycle of inputs, step the model, and check just after the edge
  task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [1:0] sel,
                               input logic [3:0] sh, input logic [11:0] bus,
                               input logic [11:0] alu, input logic rl, input logic [1:0] osel);
    cmd_valid = v; cmd_op = op; cmd_sel = sel; cmd_shamt = sh;
    bus_in = bus; alu_res = alu; r_load = rl; out_sel = osel;
    modelStep(0);
    modelStep(1);
    @(posedge clk);
    #1;
    checkModel();
  endtask

  task automatic addVec(input logic [2:0] op, input logic [1:0] sel, input logic [11:0] bus,
                        input logic [11:0] alu, input logic rl, input logic [1:0] osel,
                        input logic [11:0] e_acc0, input logic [11:0] e_acc1,
                        input logic e_c0, input logic e_c1, input logic e_z0, input logic e_z1,
                        input logic [11:0] e_opnd, input logic [11:0] e_r);
    vec_t v;
    v.op = op; v.sel = sel; v.bus = bus; v.alu = alu; v.rl = rl; v.osel = osel;
    v.e_acc0 = e_acc0; v.e_acc1 = e_acc1; v.e_c0 = e_c0; v.e_c1 = e_c1;
    v.e_z0 = e_z0; v.e_z1 = e_z1; v.e_opnd = e_opnd; v.e_r = e_r;
    vecs.push_back(v);
  endtask

  initial begin
    logic [11:0] rb;
    logic [3:0]  rsh;

    // Directed single-cycle vectors: expected values for the wrap and saturate instances
    addVec(3'd1, 2'd1, 12'hABC, 12'h000, 1'b0, 2'd1, 12'hABC, 12'hABC, 0, 0, 0, 0, 12'hABC, 12'h000);
    addVec(3'd0, 2'd0, 12'h000, 12'h000, 1'b0, 2'd0, 12'h000, 12'h000, 0, 0, 0, 0, 12'hABC, 12'h000);
    addVec(3'd1, 2'd2, 12'hFFF, 12'h000, 1'b0, 2'd2, 12'hFFF, 12'hFFF, 0, 0, 0, 0, 12'hFFF, 12'h000);
    addVec(3'd3, 2'd2, 12'h000, 12'h000, 1'b0, 2'd2, 12'h000, 12'hFFF, 1, 1, 1, 0, 12'hFFF, 12'h000);
    addVec(3'd4, 2'd2, 12'h000, 12'h000, 1'b0, 2'd2, 12'hFFF, 12'hFFE, 1, 0, 0, 0, 12'hFFF, 12'h000);
    addVec(3'd5, 2'd0, 12'h000, 12'h000, 1'b0, 2'd0, 12'h000, 12'h000, 0, 0, 1, 1, 12'hFFF, 12'h000);
    addVec(3'd4, 2'd0, 12'h000, 12'h000, 1'b0, 2'd0, 12'hFFF, 12'h000, 1, 1, 0, 1, 12'hFFF, 12'h000);
    addVec(3'd3, 2'd0, 12'h000, 12'h000, 1'b0, 2'd0, 12'h000, 12'h001, 1, 0, 1, 0, 12'hFFF, 12'h000);
    addVec(3'd2, 2'd1, 12'h123, 12'h456, 1'b1, 2'd1, 12'h456, 12'h456, 1, 0, 0, 0, 12'h456, 12'h123);
    addVec(3'd1, 2'd3, 12'h000, 12'h000, 1'b0, 2'd3, 12'h000, 12'h000, 1, 0, 1, 1, 12'h000, 12'h123);
    addVec(3'd3, 2'd3, 12'h000, 12'h000, 1'b0, 2'd1, 12'h456, 12'h456, 0, 0, 0, 0, 12'h000, 12'h123);

    // Reset state
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_sel = 2'd0; cmd_shamt = 4'd0;
    bus_in = '0; alu_res = '0; r_load = 1'b0; out_sel = 2'd0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkModel();
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven single-cycle ops
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(1'b1, vecs[i].op, vecs[i].sel, 4'd0, vecs[i].bus, vecs[i].alu,
                    vecs[i].rl, vecs[i].osel);
      checkOutput($sformatf("vec%0d_acc_sat0", i), 32'(acc_out[0]), 32'(vecs[i].e_acc0));
      checkOutput($sformatf("vec%0d_acc_sat1", i), 32'(acc_out[1]), 32'(vecs[i].e_acc1));
      checkOutput($sformatf("vec%0d_carry_sat0", i), 32'(carry[0]), 32'(vecs[i].e_c0));
      checkOutput($sformatf("vec%0d_carry_sat1", i), 32'(carry[1]), 32'(vecs[i].e_c1));
      checkOutput($sformatf("vec%0d_zero_sat0", i), 32'(zero[0]), 32'(vecs[i].e_z0));
      checkOutput($sformatf("vec%0d_zero_sat1", i), 32'(zero[1]), 32'(vecs[i].e_z1));
      checkOutput($sformatf("vec%0d_opnd", i), 32'(alu_opnd[0]), 32'(vecs[i].e_opnd));
      checkOutput($sformatf("vec%0d_r", i), 32'(r_out[1]), 32'(vecs[i].e_r));
    end

    // SHL by 3 on 0x801 while an INC is held pending
    applyStimulus(1'b1, 3'd1, 2'd3, 4'd0, 12'h801, 12'h000, 1'b0, 2'd3);
    applyStimulus(1'b1, 3'd6, 2'd3, 4'd3, 12'h000, 12'h000, 1'b0, 2'd3);
    checkOutput("shl_busy_accept", 32'(busy[0]), 1);
    checkOutput("shl_ready_accept", 32'(cmd_ready[1]), 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 3'd3, 2'd3, 4'd0, 12'h000, 12'h000, 1'b0, 2'd3);
      checkOutput($sformatf("shl_busy_c%0d", i), 32'(busy[1]), (i < 2) ? 1 : 0);
    end
    checkOutput("shl_final_sat0", 32'(acc_out[0]), 32'h008);
    checkOutput("shl_final_sat1", 32'(acc_out[1]), 32'h008);
    checkOutput("shl_carry", 32'(carry[0]), 0);
    applyStimulus(1'b1, 3'd7, 2'd3, 4'd1, 12'h000, 12'h000, 1'b0, 2'd3);
    checkOutput("shr_busy", 32'(busy[0]), 1);
    applyStimulus(1'b0, 3'd0, 2'd0, 4'd0, 12'h000, 12'h000, 1'b0, 2'd3);
    checkOutput("shr_final", 32'(acc_out[0]), 32'h004);
    checkOutput("shr_ready", 32'(cmd_ready[0]), 1);

    // Reset in the second shift cycle aborts everything at once
    applyStimulus(1'b1, 3'd6, 2'd3, 4'd5, 12'h000, 12'h000, 1'b1, 2'd3);
    applyStimulus(1'b0, 3'd0, 2'd0, 4'd0, 12'h000, 12'h000, 1'b0, 2'd3);
    rst_n = 1'b0;
    #2;
    modelReset();
    checkModel();
    checkOutput("rst_busy", 32'(busy[0]), 0);
    checkOutput("rst_acc", 32'(acc_out[1]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 3'd1, 2'd0, 4'd0, 12'h5A5, 12'h000, 1'b0, 2'd0);
    checkOutput("post_rst_load", 32'(acc_out[0]), 32'h5A5);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      case ($urandom % 4)
        0:       rb = 12'h000;
        1:       rb = 12'hFFF;
        default: rb = 12'($urandom);
      endcase
      rsh = ($urandom % 3 == 0) ? 4'($urandom % 4) : 4'($urandom);
      applyStimulus(1'(($urandom % 4) != 0), 3'($urandom), 2'($urandom), rsh, rb,
                    12'($urandom), 1'(($urandom % 3) == 0), 2'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
